// File: rtl/mem_burst_responder.sv
// Purpose : word-addressed memory model that answers burst read requests on the
//           cache refill channel, with a loader write port for preloading.
// Latency : first beat LATENCY cycles after the request is seen in IDLE; the
//           remaining beats follow back-to-back.
// Backpressure: a beat moves only on rvalid && rready. Dropping rvalid in WAIT
//           or BURST abandons the request and returns to IDLE.
// Configuration macro: MEM_RESP_STALL_EN. When defined, rready alternates
//           1,0,1,0,... inside BURST. rdata and rlast hold across the gap cycles.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   rvalid          request valid; held by the initiator until the last beat moves
//   raddr/rsize/rlen  byte address of the first beat, log2 bytes per beat, beats-1
//   rready          beat valid for the current cycle
//   rdata/rlast     beat data and final-beat marker, both zero outside BURST
//   busy            high in WAIT or BURST
//   err             sticky flag for a misaligned address or an unsupported rsize
//   ld_we/ld_addr/ld_data  loader write port, usable in any state
module mem_burst_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [31:0]           raddr,
  input  logic [2:0]            rsize,
  input  logic [7:0]            rlen,
  output logic [31:0]           rdata,
  output logic                  rlast,
  output logic                  busy,
  output logic                  err,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [31:0]           ld_data
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [7:0]            len_q;
  logic [7:0]            beat_q;
  logic [3:0]            cnt_q;
  logic                  err_q;
  logic                  beat_hi;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  unused_raddr_hi;

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Address bits above the array size are ignored; the address wraps.
  assign unused_raddr_hi = ^raddr[31:ADDR_WIDTH+2];

`ifdef MEM_RESP_STALL_EN
  logic phase_q;  // 1 during a gap cycle between beats

  assign beat_hi = ~phase_q;
  // ptr has already advanced in a gap cycle, so step back one word to hold the
  // data of the beat just delivered.
  assign rd_idx  = ptr_q - ADDR_WIDTH'(phase_q);
`else
  assign beat_hi = 1'b1;
  assign rd_idx  = ptr_q;
`endif

  assign rready = (state_q == S_BURST) && beat_hi;
  // In a gap cycle the previous beat was never the last one, so rlast stays low.
  assign rlast  = (state_q == S_BURST) && beat_hi && (beat_q == len_q);
  // The read is combinational, so a loader write in the same cycle lands after
  // this beat has been taken and the beat returns the old word.
  assign rdata  = (state_q == S_BURST) ? mem[rd_idx] : 32'h0;
  assign busy   = (state_q != S_IDLE);
  assign err    = err_q;

  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef MEM_RESP_STALL_EN
      phase_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rvalid) begin
            ptr_q  <= raddr[ADDR_WIDTH+1:2];
            len_q  <= rlen;
            beat_q <= '0;
            cnt_q  <= LAT_M1;
`ifdef MEM_RESP_STALL_EN
            phase_q <= 1'b0;
`endif
            if ((raddr[1:0] != 2'b00) || (rsize != 3'h2)) begin
              err_q <= 1'b1;
            end
            state_q <= (LAT_M1 == 4'd0) ? S_BURST : S_WAIT;
          end
        end

        S_WAIT: begin
          if (!rvalid) begin
            state_q <= S_IDLE;
          end else if (cnt_q <= 4'd1) begin
            // The count reaches zero on this edge, so BURST starts next cycle.
            cnt_q   <= 4'd0;
            state_q <= S_BURST;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        S_BURST: begin
          if (!rvalid) begin
            state_q <= S_IDLE;
          end else begin
`ifdef MEM_RESP_STALL_EN
            if (phase_q) begin
              phase_q <= 1'b0;
            end else begin
              phase_q <= 1'b1;
              ptr_q   <= ptr_q + ADDR_WIDTH'(1);
              beat_q  <= beat_q + 8'd1;
              if (beat_q == len_q) begin
                phase_q <= 1'b0;
                state_q <= S_IDLE;
              end
            end
`else
            ptr_q  <= ptr_q + ADDR_WIDTH'(1);
            beat_q <= beat_q + 8'd1;
            if (beat_q == len_q) begin
              state_q <= S_IDLE;
            end
`endif
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_responder.sv
// Directed bench for mem_burst_responder: table-driven bursts plus hand-written
// sequences for abort, loader collision, error flag and mid-burst reset.
module tb_mem_burst_responder;

  localparam int AW  = 10;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          rvalid;
  logic          rready;
  logic [31:0]   raddr;
  logic [2:0]    rsize;
  logic [7:0]    rlen;
  logic [31:0]   rdata;
  logic          rlast;
  logic          busy;
  logic          err;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0]      raddr;
    logic [7:0]       rlen;
    logic [0:3][31:0] exp;
  } vec_t;

  vec_t vecs [5];

  mem_burst_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .rvalid  (rvalid),
    .rready  (rready),
    .raddr   (raddr),
    .rsize   (rsize),
    .rlen    (rlen),
    .rdata   (rdata),
    .rlast   (rlast),
    .busy    (busy),
    .err     (err),
    .ld_we   (ld_we),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Issue a request in the current (IDLE) cycle and check every cycle up to and
  // including the first IDLE cycle after the last beat.
  task automatic run_burst(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [0:3][31:0] e,
                           input string nm);
    rvalid = 1'b1;
    raddr  = addr;
    rlen   = len;
    rsize  = size;
    for (int w = 1; w < LAT; w++) begin
      tick();
      chk({nm, " wait rready"}, 32'(rready), 32'd0);
      chk({nm, " wait busy"}, 32'(busy), 32'd1);
    end
    for (int b = 0; b <= int'(len); b++) begin
      tick();
`ifdef MEM_RESP_STALL_EN
      if (b > 0) begin
        chk({nm, " gap rready"}, 32'(rready), 32'd0);
        chk({nm, " gap rdata"}, rdata, e[b-1]);
        chk({nm, " gap rlast"}, 32'(rlast), 32'd0);
        tick();
      end
`endif
      chk({nm, " beat rready"}, 32'(rready), 32'd1);
      chk({nm, " beat rdata"}, rdata, e[b]);
      chk({nm, " beat rlast"}, 32'(rlast), 32'(b == int'(len)));
    end
    tick();
    rvalid = 1'b0;
    chk({nm, " end busy"}, 32'(busy), 32'd0);
    chk({nm, " end rready"}, 32'(rready), 32'd0);
    chk({nm, " end rdata"}, rdata, 32'd0);
  endtask

  // Tick until n beats have been offered while rvalid is high; stop in the
  // cycle holding the n-th beat. Bounded so a dead DUT cannot hang the bench.
  task automatic wait_beats(input int n, input string nm);
    int seen = 0;
    for (int c = 0; c < 40 && seen < n; c++) begin
      tick();
      if (rready && rvalid) seen++;
    end
    chk({nm, " beats seen"}, 32'(seen), 32'(n));
  endtask

  initial begin
    vecs[0] = '{raddr: 32'h0000_0040, rlen: 8'd3,
                exp: {32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3}};
    vecs[1] = '{raddr: 32'h0000_0FF8, rlen: 8'd3,
                exp: {32'hB000_03FE, 32'hB000_03FF, 32'hB000_0000, 32'hB000_0001}};
    vecs[2] = '{raddr: 32'h0000_0080, rlen: 8'd0,
                exp: {32'hB000_0020, 32'h0, 32'h0, 32'h0}};
    vecs[3] = '{raddr: 32'h0000_0044, rlen: 8'd1,
                exp: {32'h0000_00A1, 32'h0000_00A2, 32'h0, 32'h0}};
    vecs[4] = '{raddr: 32'h0000_1000, rlen: 8'd1,
                exp: {32'hB000_0000, 32'hB000_0001, 32'h0, 32'h0}};

    rst     = 1'b1;
    rvalid  = 1'b0;
    raddr   = '0;
    rsize   = 3'h2;
    rlen    = '0;
    ld_we   = 1'b0;
    ld_addr = '0;
    ld_data = '0;

    tick();
    chk("reset rready", 32'(rready), 32'd0);
    chk("reset rlast", 32'(rlast), 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    // Every word i holds 0xB000_0000+i, then words 0x10..0x13 hold 0xA0..0xA3.
    for (int i = 0; i < (1 << AW); i++) begin
      ld_we   = 1'b1;
      ld_addr = AW'(i);
      ld_data = 32'hB000_0000 + 32'(i);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      ld_addr = AW'(16 + i);
      ld_data = 32'h0000_00A0 + 32'(i);
      tick();
    end
    ld_we = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_burst(vecs[i].raddr, vecs[i].rlen, 3'h2, vecs[i].exp, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d err", i), 32'(err), 32'd0);
    end

    // Abort while waiting for the first beat.
    rvalid = 1'b1; raddr = 32'h40; rlen = 8'd3; rsize = 3'h2;
    tick();
    chk("wait-abort busy in WAIT", 32'(busy), 32'd1);
    rvalid = 1'b0;
    tick();
    chk("wait-abort busy", 32'(busy), 32'd0);
    tick();
    chk("wait-abort no beat", 32'(rready), 32'd0);

    // Abort after the second beat of an 8-beat burst.
    rvalid = 1'b1; raddr = 32'h40; rlen = 8'd7;
    wait_beats(2, "abort");
    chk("abort beat1 rdata", rdata, 32'h0000_00A1);
    tick();
    rvalid = 1'b0;
    tick();
    chk("abort idle busy", 32'(busy), 32'd0);
    chk("abort idle rready", 32'(rready), 32'd0);
    tick();
    chk("abort no 3rd beat", 32'(rready), 32'd0);
    run_burst(32'h0, 8'd0, 3'h2, {32'hB000_0000, 32'h0, 32'h0, 32'h0}, "post-abort");

    // Loader write to the word being read in the same cycle: old data wins.
    rvalid = 1'b1; raddr = 32'h80; rlen = 8'd0;
    for (int w = 0; w < LAT; w++) tick();
    ld_we = 1'b1; ld_addr = AW'(32'h20); ld_data = 32'hDEAD_BEEF;
    chk("collide rready", 32'(rready), 32'd1);
    chk("collide old data", rdata, 32'hB000_0020);
    tick();
    ld_we  = 1'b0;
    rvalid = 1'b0;
    chk("collide busy", 32'(busy), 32'd0);
    run_burst(32'h80, 8'd0, 3'h2, {32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0}, "collide new");

    // Sticky error flag.
    run_burst(32'h40, 8'd0, 3'h1, {32'h0000_00A0, 32'h0, 32'h0, 32'h0}, "err rsize");
    chk("err after bad rsize", 32'(err), 32'd1);
    run_burst(32'h44, 8'd0, 3'h2, {32'h0000_00A1, 32'h0, 32'h0, 32'h0}, "err clean");
    chk("err sticky", 32'(err), 32'd1);
    rst = 1'b1;
    #1;
    chk("err cleared by reset", 32'(err), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_burst(32'h42, 8'd0, 3'h2, {32'h0000_00A0, 32'h0, 32'h0, 32'h0}, "err misalign");
    chk("err after misalign", 32'(err), 32'd1);

    // Reset during beat 1 of a burst.
    rvalid = 1'b1; raddr = 32'h40; rlen = 8'd3; rsize = 3'h2;
    wait_beats(2, "rstmid");
    chk("rstmid rready before", 32'(rready), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid rready", 32'(rready), 32'd0);
    chk("rstmid rlast", 32'(rlast), 32'd0);
    chk("rstmid busy", 32'(busy), 32'd0);
    chk("rstmid rdata", rdata, 32'd0);
    chk("rstmid err", 32'(err), 32'd0);
    rvalid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    run_burst(32'h40, 8'd3, 3'h2,
              {32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3}, "after rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
